alarm_clock_ctrl: RTL and testbench

- Hardware timekeeping and alarm controller for the alarm-clock SoC: 1 Hz prescaler, BCD HH:MM:SS time counter, alarm register, button conditioning and a mode FSM.
- Drives the six 4-bit BCD display digit outputs and the alarm line.
- Takes the three raw push-buttons (set_alarm, up, down), offloading timekeeping from the soft CPU.

---
 rtl/alarm_clock_ctrl_if.sv | 29 ++
 rtl/alarm_clock_ctrl.sv | 249 ++++++++++++++++++++++++
 tb/tb_alarm_clock_ctrl.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/alarm_clock_ctrl_if.sv
// rtl/alarm_clock_ctrl_if.sv - button inputs and display/alarm outputs of the alarm clock controller
interface alarm_clock_ctrl_if;
    logic       btn_set_alarm;
    logic       btn_up;
    logic       btn_down;
    logic [3:0] display_h1;
    logic [3:0] display_h0;
    logic [3:0] display_m1;
    logic [3:0] display_m0;
    logic [3:0] display_s1;
    logic [3:0] display_s0;
    logic       alarm;
    logic       mode_alarm;
    logic       tick_1hz;

    // Environment side: drives the raw buttons, observes the display.
    modport master (
        output btn_set_alarm, btn_up, btn_down,
        input  display_h1, display_h0, display_m1, display_m0, display_s1, display_s0,
        input  alarm, mode_alarm, tick_1hz
    );

    // Controller side.
    modport slave (
        input  btn_set_alarm, btn_up, btn_down,
        output display_h1, display_h0, display_m1, display_m0, display_s1, display_s0,
        output alarm, mode_alarm, tick_1hz
    );
endinterface

// File: rtl/alarm_clock_ctrl.sv
// rtl/alarm_clock_ctrl.sv - 1 Hz timekeeping, alarm register, button conditioning and mode FSM
module alarm_clock_ctrl #(
    parameter int CLK_HZ          = 50000000,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int ALARM_SECONDS   = 60
) (
    input  logic              clk_clk,
    input  logic              reset_reset,
    alarm_clock_ctrl_if.slave bus
);
    localparam int PRE_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam int DEB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int ALM_W = $clog2(ALARM_SECONDS + 1);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_HZ - 1);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [ALM_W-1:0] ALM_LAST = ALM_W'(ALARM_SECONDS - 1);

    typedef enum logic [2:0] {
        ST_RUN     = 3'd0,
        ST_AL_HOUR = 3'd1,
        ST_AL_MIN  = 3'd2,
        ST_TM_HOUR = 3'd3,
        ST_TM_MIN  = 3'd4
    } state_t;

    // Button bit order: 0 = set_alarm, 1 = up, 2 = down.
    logic [2:0]       sync1_q, sync1_d;
    logic [2:0]       sync2_q, sync2_d;
    logic [2:0]       deb_q, deb_d;
    logic [2:0]       deb_prev_q, deb_prev_d;
    logic [DEB_W-1:0] cnt_q [3];
    logic [DEB_W-1:0] cnt_d [3];
    logic [2:0]       press;

    state_t           state_q, state_d;
    logic             mode_alarm_w;
    logic             time_hold;

    logic [PRE_W-1:0] pre_q, pre_d;
    logic [5:0]       hour_q, hour_d, min_q, min_d, sec_q, sec_d;
    logic [5:0]       al_hour_q, al_hour_d, al_min_q, al_min_d;
    logic             armed_q, armed_d;
    logic             tick_q, tick_d;
    logic             alarm_q, alarm_d;
    logic [ALM_W-1:0] alm_cnt_q, alm_cnt_d;

    logic             tick;
    logic             dismiss, set_ev, inc_ev, dec_ev, adj_ev, match;
    logic [5:0]       disp_hour, disp_min, disp_sec;
    logic [7:0]       hh_bcd, mm_bcd, ss_bcd;

    function automatic logic [5:0] wrap_step(input logic [5:0] v, input logic [5:0] last,
                                             input logic up);
        if (up) begin
            return (v == last) ? 6'd0 : v + 6'd1;
        end
        return (v == 6'd0) ? last : v - 6'd1;
    endfunction

    function automatic logic [7:0] to_bcd(input logic [5:0] v);
        logic [5:0] tens;
        logic [5:0] units;
        tens  = v / 6'd10;
        units = v % 6'd10;
        return {tens[3:0], units[3:0]};
    endfunction

    // Synchronize raw buttons, accept a level only after it has been stable long enough.
    always_comb begin
        sync1_d    = {bus.btn_down, bus.btn_up, bus.btn_set_alarm};
        sync2_d    = sync1_q;
        deb_prev_d = deb_q;
        deb_d      = deb_q;
        for (int i = 0; i < 3; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != deb_q[i]) begin
                if (cnt_q[i] == DEB_LAST) begin
                    deb_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    assign press = deb_q & ~deb_prev_q;

    // Press arbitration: an alarm swallows every press, set_alarm beats up/down,
    // and up together with down cancels out.
    always_comb begin
        dismiss = alarm_q && (|press);
        set_ev  = press[0] && !dismiss;
        inc_ev  = !dismiss && !press[0] && press[1] && !press[2];
        dec_ev  = !dismiss && !press[0] && press[2] && !press[1];
        adj_ev  = inc_ev || dec_ev;
    end

    // Button conditioning registers.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            deb_q      <= '0;
            deb_prev_q <= '0;
            for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            deb_q      <= deb_d;
            deb_prev_q <= deb_prev_d;
            for (int i = 0; i < 3; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    // FSM state register.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: each set_alarm press moves one step round the ring.
    always_comb begin
        state_d = state_q;
        if (set_ev) begin
            case (state_q)
                ST_RUN:     state_d = ST_AL_HOUR;
                ST_AL_HOUR: state_d = ST_AL_MIN;
                ST_AL_MIN:  state_d = ST_TM_HOUR;
                ST_TM_HOUR: state_d = ST_TM_MIN;
                default:    state_d = ST_RUN;
            endcase
        end
    end

    // FSM outputs: which register is displayed and whether time is frozen.
    always_comb begin
        mode_alarm_w = (state_q == ST_AL_HOUR) || (state_q == ST_AL_MIN);
        time_hold    = (state_q == ST_TM_HOUR) || (state_q == ST_TM_MIN);
    end

    // Prescaler, time counter, alarm register and alarm timer next-state logic.
    always_comb begin
        tick  = !time_hold && (pre_q == PRE_LAST);
        pre_d = (time_hold || pre_q == PRE_LAST) ? '0 : pre_q + 1'b1;

        sec_d  = sec_q;
        min_d  = min_q;
        hour_d = hour_q;
        if (tick) begin
            if (sec_q == 6'd59) begin
                sec_d = 6'd0;
                if (min_q == 6'd59) begin
                    min_d  = 6'd0;
                    hour_d = (hour_q == 6'd23) ? 6'd0 : hour_q + 6'd1;
                end else begin
                    min_d = min_q + 6'd1;
                end
            end else begin
                sec_d = sec_q + 6'd1;
            end
        end
        // Time setting starts from a clean minute boundary.
        if (state_q == ST_AL_MIN && set_ev) sec_d = 6'd0;
        if (state_q == ST_TM_HOUR && adj_ev) hour_d = wrap_step(hour_q, 6'd23, inc_ev);
        if (state_q == ST_TM_MIN && adj_ev) min_d = wrap_step(min_q, 6'd59, inc_ev);

        al_hour_d = al_hour_q;
        al_min_d  = al_min_q;
        if (state_q == ST_AL_HOUR && adj_ev) al_hour_d = wrap_step(al_hour_q, 6'd23, inc_ev);
        if (state_q == ST_AL_MIN && adj_ev) al_min_d = wrap_step(al_min_q, 6'd59, inc_ev);

        armed_d = armed_q || (state_q == ST_AL_MIN && set_ev);
        tick_d  = tick;

        // Only the cycle right after the tick that reached :00 can fire, so a
        // dismissed or expired alarm stays quiet for the rest of that minute.
        match = (state_q == ST_RUN) && armed_q && tick_q && (sec_q == 6'd0) &&
                (hour_q == al_hour_q) && (min_q == al_min_q);

        alarm_d   = alarm_q;
        alm_cnt_d = alm_cnt_q;
        if (dismiss) begin
            alarm_d   = 1'b0;
            alm_cnt_d = '0;
        end else if (alarm_q) begin
            if (tick) begin
                if (alm_cnt_q == ALM_LAST) begin
                    alarm_d   = 1'b0;
                    alm_cnt_d = '0;
                end else begin
                    alm_cnt_d = alm_cnt_q + 1'b1;
                end
            end
        end else if (match) begin
            alarm_d   = 1'b1;
            alm_cnt_d = '0;
        end
    end

    // Timekeeping and alarm registers.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            pre_q     <= '0;
            hour_q    <= 6'd0;
            min_q     <= 6'd0;
            sec_q     <= 6'd0;
            al_hour_q <= 6'd6;
            al_min_q  <= 6'd0;
            armed_q   <= 1'b0;
            tick_q    <= 1'b0;
            alarm_q   <= 1'b0;
            alm_cnt_q <= '0;
        end else begin
            pre_q     <= pre_d;
            hour_q    <= hour_d;
            min_q     <= min_d;
            sec_q     <= sec_d;
            al_hour_q <= al_hour_d;
            al_min_q  <= al_min_d;
            armed_q   <= armed_d;
            tick_q    <= tick_d;
            alarm_q   <= alarm_d;
            alm_cnt_q <= alm_cnt_d;
        end
    end

    // Display selection and BCD conversion.
    always_comb begin
        disp_hour = mode_alarm_w ? al_hour_q : hour_q;
        disp_min  = mode_alarm_w ? al_min_q : min_q;
        disp_sec  = mode_alarm_w ? 6'd0 : sec_q;
        hh_bcd    = to_bcd(disp_hour);
        mm_bcd    = to_bcd(disp_min);
        ss_bcd    = to_bcd(disp_sec);
    end

    assign bus.display_h1 = hh_bcd[7:4];
    assign bus.display_h0 = hh_bcd[3:0];
    assign bus.display_m1 = mm_bcd[7:4];
    assign bus.display_m0 = mm_bcd[3:0];
    assign bus.display_s1 = ss_bcd[7:4];
    assign bus.display_s0 = ss_bcd[3:0];
    assign bus.alarm      = alarm_q;
    assign bus.mode_alarm = mode_alarm_w;
    assign bus.tick_1hz   = tick;
endmodule

// File: tb/tb_alarm_clock_ctrl.sv
// tb/tb_alarm_clock_ctrl.sv - scoreboard testbench for alarm_clock_ctrl
module tb_alarm_clock_ctrl;
    localparam int CLK_HZ = 10;
    localparam int DEB    = 4;
    localparam int ALS    = 3;

    localparam int S_DIG   = 0;
    localparam int S_ALARM = 1;
    localparam int S_MODE  = 2;
    localparam int S_TICK  = 3;
    localparam int S_NTICK = 4;

    logic clk_clk     = 1'b0;
    logic reset_reset = 1'b1;

    alarm_clock_ctrl_if bus ();

    alarm_clock_ctrl #(
        .CLK_HZ          (CLK_HZ),
        .DEBOUNCE_CYCLES (DEB),
        .ALARM_SECONDS   (ALS)
    ) dut (
        .clk_clk     (clk_clk),
        .reset_reset (reset_reset),
        .bus         (bus)
    );

    always #5 clk_clk = ~clk_clk;

    int cyc = 0;
    always @(posedge clk_clk) cyc <= cyc + 1;

    int ntick = 0;
    always @(posedge clk_clk) begin
        if (reset_reset) ntick <= 0;
        else if (bus.tick_1hz) ntick <= ntick + 1;
    end

    typedef struct {
        int    cyc;
        string name;
        int    sel;
        int    exp;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    function automatic int observe(int sel);
        case (sel)
            S_DIG:   return int'({bus.display_h1, bus.display_h0, bus.display_m1,
                                  bus.display_m0, bus.display_s1, bus.display_s0});
            S_ALARM: return int'(bus.alarm);
            S_MODE:  return int'(bus.mode_alarm);
            S_TICK:  return int'(bus.tick_1hz);
            S_NTICK: return ntick;
            default: return -1;
        endcase
    endfunction

    // Monitor: compares every expectation due in this cycle, on the falling edge.
    always @(negedge clk_clk) begin
        exp_t e;
        int   act;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e   = sb.pop_front();
            act = (e.cyc == cyc) ? observe(e.sel) : -1;
            tests++;
            if (act != e.exp) begin
                fails++;
                $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", e.name, act, e.exp, cyc);
            end
        end
    end

    task automatic step(int n);
        repeat (n) begin
            @(posedge clk_clk);
            #1;
        end
    endtask

    task automatic chk(string name, int sel, int exp);
        exp_t e;
        e.cyc  = cyc;
        e.name = name;
        e.sel  = sel;
        e.exp  = exp;
        sb.push_back(e);
    endtask

    task automatic do_reset();
        reset_reset = 1'b1;
        step(1);
        reset_reset = 1'b0;
    endtask

    // m bit 0 = set_alarm, bit 1 = up, bit 2 = down
    task automatic press(logic [2:0] m);
        {bus.btn_down, bus.btn_up, bus.btn_set_alarm} = m;
        step(12);
        {bus.btn_down, bus.btn_up, bus.btn_set_alarm} = 3'b000;
        step(12);
    endtask

    task automatic wait_digits(string name, int target, int limit);
        int n = 0;
        while (observe(S_DIG) != target && n < limit) begin
            step(1);
            n++;
        end
        chk(name, S_DIG, target);
    endtask

    task automatic wait_tick();
        int n = 0;
        while (bus.tick_1hz !== 1'b1 && n < 2 * CLK_HZ) begin
            step(1);
            n++;
        end
        chk("tick_seen", S_TICK, 1);
        step(1);
    endtask

    // From reset: alarm 06:00 -> 00:01, arm, time to 00:00:00, back to RUN.
    task automatic setup_alarm_0001();
        do_reset();
        press(3'b001);
        repeat (6) press(3'b100);
        press(3'b001);
        press(3'b010);
        chk("al_set_0001", S_DIG, 32'h000100);
        press(3'b001);
        chk("tm_entry_zero", S_DIG, 32'h000000);
        chk("tm_mode", S_MODE, 0);
        press(3'b001);
        press(3'b001);
    endtask

    initial begin
        logic [11:0] bounce;
        bounce = 12'b0111_0010_1101;
        bus.btn_set_alarm = 1'b0;
        bus.btn_up        = 1'b0;
        bus.btn_down      = 1'b0;

        // Reset state and ten seconds of free running.
        reset_reset = 1'b1;
        step(2);
        reset_reset = 1'b0;
        chk("rst_digits", S_DIG, 32'h000000);
        chk("rst_alarm", S_ALARM, 0);
        chk("rst_mode", S_MODE, 0);
        chk("rst_tick", S_TICK, 0);
        step(99);
        chk("run_9s", S_DIG, 32'h000009);
        chk("tick_at_tc", S_TICK, 1);
        step(1);
        chk("run_10s", S_DIG, 32'h000010);
        chk("tick_count", S_NTICK, 10);
        chk("run_alarm", S_ALARM, 0);

        // Preload 23:59 through the time-setting states and roll over midnight.
        do_reset();
        press(3'b001);
        press(3'b001);
        press(3'b001);
        chk("tmh_mode", S_MODE, 0);
        chk("tmh_digits", S_DIG, 32'h000000);
        press(3'b100);
        chk("tmh_dec_wrap", S_DIG, 32'h230000);
        press(3'b010);
        chk("tmh_inc_wrap", S_DIG, 32'h000000);
        press(3'b100);
        press(3'b001);
        press(3'b100);
        chk("tmm_dec_wrap", S_DIG, 32'h235900);
        press(3'b001);
        wait_digits("reach_235958", 32'h235958, 700);
        wait_tick();
        chk("wrap_235959", S_DIG, 32'h235959);
        wait_tick();
        chk("wrap_midnight", S_DIG, 32'h000000);

        // Bouncing button in AL_HOUR: glitches ignored, one clean press counts once.
        do_reset();
        press(3'b001);
        chk("alh_mode", S_MODE, 1);
        chk("alh_default", S_DIG, 32'h060000);
        repeat (6) press(3'b100);
        chk("alh_to_00", S_DIG, 32'h000000);
        for (int i = 0; i < 12; i++) begin
            bus.btn_up = bounce[i];
            step(1);
        end
        bus.btn_up = 1'b0;
        step(8);
        chk("bounce_ignored", S_DIG, 32'h000000);
        press(3'b010);
        chk("bounce_one_inc", S_DIG, 32'h010000);
        press(3'b100);
        chk("alh_dec_00", S_DIG, 32'h000000);
        press(3'b100);
        chk("alh_dec_wrap23", S_DIG, 32'h230000);

        // Alarm fires on the 00:01:00 tick and expires after three ticks.
        setup_alarm_0001();
        wait_digits("reach_000100", 32'h000100, 700);
        chk("alarm_tick_cycle", S_ALARM, 0);
        step(1);
        chk("alarm_rise", S_ALARM, 1);
        wait_tick();
        chk("alarm_hold1", S_ALARM, 1);
        wait_tick();
        chk("alarm_hold2", S_ALARM, 1);
        wait_tick();
        chk("alarm_fall", S_ALARM, 0);
        chk("alarm_fall_time", S_DIG, 32'h000103);

        // Dismiss with btn_down: drops DEB+3 cycles after the raw edge, press consumed.
        setup_alarm_0001();
        wait_digits("reach_000100b", 32'h000100, 700);
        step(1);
        chk("alarm_rise_b", S_ALARM, 1);
        bus.btn_down = 1'b1;
        step(DEB + 2);
        chk("alarm_pre_dismiss", S_ALARM, 1);
        step(1);
        chk("alarm_dismissed", S_ALARM, 0);
        step(5);
        bus.btn_down = 1'b0;
        step(12);
        chk("dismiss_no_mode", S_MODE, 0);
        chk("dismiss_no_refire", S_ALARM, 0);
        press(3'b001);
        chk("dismiss_al_unchanged", S_DIG, 32'h000100);

        // Simultaneous events, minute wrap, then reset in the middle of setting.
        do_reset();
        press(3'b011);
        chk("set_wins_mode", S_MODE, 1);
        chk("set_wins_hour", S_DIG, 32'h060000);
        press(3'b001);
        press(3'b110);
        chk("updown_ignored", S_DIG, 32'h060000);
        press(3'b010);
        chk("alm_inc", S_DIG, 32'h060100);
        press(3'b100);
        press(3'b100);
        chk("alm_dec_wrap", S_DIG, 32'h065900);
        do_reset();
        chk("midset_rst_digits", S_DIG, 32'h000000);
        chk("midset_rst_mode", S_MODE, 0);
        chk("midset_rst_alarm", S_ALARM, 0);
        press(3'b001);
        chk("midset_rst_alreg", S_DIG, 32'h060000);

        step(3);
        if (sb.size() != 0) begin
            fails += sb.size();
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
